lsu_mem_port: RTL and testbench
===============================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width driven on mem_addr_o.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  synchronous pipeline kill (exception/branch recovery).
REQ-005 iq_lsu_valid_i  in  1  request valid from the issue queue.
REQ-006 iq_lsu_ready_o  out  1  this block can accept a request this cycle.
REQ-007 iq_lsu_req_i  in  iq_lsu_pkg_t  fields: wid, msigned, msize, vaddr, wdata, rmask, strb.
REQ-008 lsu_iq_valid_o  out  1  response valid toward the issue queue / result FIFO.
REQ-009 lsu_iq_ready_i  in  1  downstream can take the response.
REQ-010 lsu_iq_resp_o  out  lsu_iq_pkg_t  fields: rdata, execute_exc_info{execute_exception, exc_code, badv}.
REQ-011 mem_en_o  out  1  SRAM access enable; mem_we_o  out  4  byte write strobes.
REQ-012 mem_addr_o  out  ADDR_W  word-aligned address; mem_wdata_o  out  32  lane-aligned store data.
REQ-013 mem_rdata_i  in  32  SRAM read data, valid exactly one cycle after a mem_en_o read.

Function
REQ-014 Handshake: accept on iq_lsu_valid_i && iq_lsu_ready_o; iq_lsu_ready_o = !m2_valid || lsu_iq_ready_i (combinational).
REQ-015 Pipeline: stage M1 is the accept cycle; stage M2 register holds wid, msize, msigned, vaddr[1:0], is_store, exception info.
REQ-016 Latency: accepted at cycle T -> lsu_iq_valid_o asserted from T+1, held until lsu_iq_ready_i; throughput one per cycle.
REQ-017 Misalign: msize=1 with vaddr[0]!=0, or msize=2 with vaddr[1:0]!=0 -> no SRAM access; response execute_exception=1, exc_code=EXC_ALE, badv=vaddr, rdata=0.
REQ-018 Load (strb==0, aligned): mem_en_o=1, mem_we_o=0, mem_addr_o={vaddr[ADDR_W-1:2],2'b00} in cycle T.
REQ-019 Store (strb!=0, aligned): mem_en_o=1, mem_we_o=strb, mem_wdata_o=wdata<<(8*vaddr[1:0]); response rdata=0, no exception.
REQ-020 Load data: byte/half from lane vaddr[1:0], sign-extended when msigned else zero-extended; msize=2 passes word unchanged.
REQ-021 M2 FSM states: IDLE (no response), LIVE (rdata taken from mem_rdata_i), HOLD (rdata from hold register).
REQ-022 IDLE->LIVE on accept; LIVE with lsu_iq_ready_i -> LIVE on new accept else IDLE.
REQ-023 LIVE without lsu_iq_ready_i -> HOLD, capturing aligned rdata into hold register that cycle.
REQ-024 HOLD with lsu_iq_ready_i -> LIVE on new accept else IDLE; HOLD without ready stays HOLD, register unchanged.
REQ-025 Exceptions and stores carry rdata=0 regardless of state; no SRAM read is consumed.
REQ-026 flush: M2 -> IDLE next cycle, pending response dropped; iq_lsu_ready_o forced 0 and mem_en_o forced 0 during the flush cycle.
REQ-027 A store written before flush is not undone; flush in HOLD discards hold register.
REQ-028 lsu_iq_resp_o stable while lsu_iq_valid_o && !lsu_iq_ready_i.

Reset
REQ-029 rst_n low: FSM=IDLE, lsu_iq_valid_o=0, mem_en_o=0, mem_we_o=0, lsu_iq_resp_o=0, hold register=0; iq_lsu_ready_o=1 once rst_n is high.
REQ-030 Reset asserted mid-response clears state immediately; first response after release requires a new accept.

Structure
REQ-031 iq_lsu_pkg_t, lsu_iq_pkg_t, exc-info types and EXC_ALE (6'h09) live in the shared defines header.
REQ-032 Sub-module lsu_load_align: combinational lane select and sign/zero extension, instantiated once on the M2 path.
REQ-033 Target 150-300 lines of RTL; no RAM inside this block.

Verification
REQ-034 Load word vaddr=0x100, SRAM[0x100]=0xDEADBEEF, ready=1 -> T: mem_en_o=1, addr 0x100; T+1: valid, rdata=0xDEADBEEF.
REQ-035 Signed byte load vaddr=0x103, word=0x80112233 -> rdata=0xFFFFFF80; same load unsigned -> 0x00000080.
REQ-036 Store half vaddr=0x202, wdata=0x0000ABCD, strb=4'b1100 -> mem_we_o=4'b1100, mem_wdata_o=0xABCD0000; response rdata=0, no exception.
REQ-037 Load word vaddr=0x105 -> mem_en_o=0, response exception=1, exc_code=0x09, badv=0x105.
REQ-038 Back-to-back loads 0x10, 0x14 with lsu_iq_ready_i low 3 cycles after first -> FSM HOLD, iq_lsu_ready_o=0, first rdata stable; on ready, both delivered in order.
REQ-039 flush while HOLD, then rst_n pulse mid-LIVE -> lsu_iq_valid_o=0 next cycle / immediately, no stale response afterwards.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the LSU <-> issue-queue interface and the LSU memory port.
// Holds request/response structs, exception codes, M2 FSM encodings and the alignment check.
package lsu_mem_port_pkg;

  localparam int WID_W = 4;

  localparam logic [5:0] EXC_ALE = 6'h09;

  localparam logic [1:0] MSIZE_B = 2'd0;
  localparam logic [1:0] MSIZE_H = 2'd1;
  localparam logic [1:0] MSIZE_W = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LIVE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef struct packed {
    logic        execute_exception;
    logic [5:0]  exc_code;
    logic [31:0] badv;
  } exc_info_t;

  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic             msigned;
    logic [1:0]       msize;
    logic [31:0]      vaddr;
    logic [31:0]      wdata;
    logic [3:0]       rmask;
    logic [3:0]       strb;
  } iq_lsu_pkg_t;

  typedef struct packed {
    logic [31:0] rdata;
    exc_info_t   execute_exc_info;
  } lsu_iq_pkg_t;

  function automatic logic is_misaligned(input logic [1:0] msize, input logic [1:0] offset);
    return ((msize == MSIZE_H) && offset[0]) || ((msize == MSIZE_W) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_align.sv
// Picks the addressed byte/half lane out of an SRAM word and sign- or zero-extends it.
// Word accesses are always aligned, so the shifted word is returned unchanged for them.
module lsu_load_align
  import lsu_mem_port_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  msize,
  input  logic        msigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    data    = shifted;
    case (msize)
      MSIZE_B: data = {{24{msigned & shifted[7]}}, shifted[7:0]};
      MSIZE_H: data = {{16{msigned & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Two-stage LSU memory port: M1 issues the SRAM access on accept, M2 returns the response.
// M2 parks read data in a hold register while the consumer stalls so the response stays stable.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              iq_lsu_valid_i,
  output logic              iq_lsu_ready_o,
  input  iq_lsu_pkg_t       iq_lsu_req_i,
  output logic              lsu_iq_valid_o,
  input  logic              lsu_iq_ready_i,
  output lsu_iq_pkg_t       lsu_iq_resp_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  logic [1:0]       m2_state;
  logic [1:0]       m2_state_nxt;
  logic [WID_W-1:0] m2_wid;
  logic [1:0]       m2_msize;
  logic             m2_msigned;
  logic [1:0]       m2_offset;
  logic             m2_is_store;
  exc_info_t        m2_exc;
  logic [31:0]      hold_rdata;
  logic [31:0]      aligned_rdata;
  logic [31:0]      resp_rdata;
  logic             m2_valid;
  logic             accept;
  logic             req_misaligned;
  logic             unused_sink;

  // wid rides along in M2 for result tracking; rmask is not needed to drive the SRAM
  assign unused_sink = ^{m2_wid, iq_lsu_req_i.rmask};

  assign m2_valid       = (m2_state != ST_IDLE);
  assign iq_lsu_ready_o = rst_n && !flush && (!m2_valid || lsu_iq_ready_i);
  assign accept         = iq_lsu_valid_i && iq_lsu_ready_o;
  assign req_misaligned = is_misaligned(iq_lsu_req_i.msize, iq_lsu_req_i.vaddr[1:0]);

  // Misaligned requests never touch the SRAM; they only produce an exception response
  assign mem_en_o    = accept && !req_misaligned;
  assign mem_we_o    = mem_en_o ? iq_lsu_req_i.strb : 4'b0000;
  assign mem_addr_o  = {iq_lsu_req_i.vaddr[ADDR_W-1:2], 2'b00};
  assign mem_wdata_o = iq_lsu_req_i.wdata << {iq_lsu_req_i.vaddr[1:0], 3'b000};

  lsu_load_align u_load_align (
    .word    (mem_rdata_i),
    .offset  (m2_offset),
    .msize   (m2_msize),
    .msigned (m2_msigned),
    .data    (aligned_rdata)
  );

  always_comb begin
    m2_state_nxt = m2_state;
    case (m2_state)
      ST_IDLE: if (accept) m2_state_nxt = ST_LIVE;
      ST_LIVE, ST_HOLD: begin
        if (lsu_iq_ready_i) m2_state_nxt = accept ? ST_LIVE : ST_IDLE;
        else                m2_state_nxt = ST_HOLD;
      end
      default: m2_state_nxt = ST_IDLE;
    endcase
    if (flush) m2_state_nxt = ST_IDLE;
  end

  // Stores and exceptions return zero data whatever the SRAM read port shows
  always_comb begin
    resp_rdata = 32'h0;
    if (!m2_is_store && !m2_exc.execute_exception)
      resp_rdata = (m2_state == ST_LIVE) ? aligned_rdata : hold_rdata;
  end

  always_comb begin
    lsu_iq_resp_o = '0;
    if (m2_valid) begin
      lsu_iq_resp_o.rdata            = resp_rdata;
      lsu_iq_resp_o.execute_exc_info = m2_exc;
    end
  end

  assign lsu_iq_valid_o = m2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_state    <= ST_IDLE;
      m2_wid      <= '0;
      m2_msize    <= 2'b00;
      m2_msigned  <= 1'b0;
      m2_offset   <= 2'b00;
      m2_is_store <= 1'b0;
      m2_exc      <= '0;
      hold_rdata  <= 32'h0;
    end else begin
      m2_state <= m2_state_nxt;
      if (accept) begin
        m2_wid      <= iq_lsu_req_i.wid;
        m2_msize    <= iq_lsu_req_i.msize;
        m2_msigned  <= iq_lsu_req_i.msigned;
        m2_offset   <= iq_lsu_req_i.vaddr[1:0];
        m2_is_store <= (iq_lsu_req_i.strb != 4'b0000);
        m2_exc      <= req_misaligned ? '{1'b1, EXC_ALE, iq_lsu_req_i.vaddr} : '0;
      end
      // SRAM data is only valid in the LIVE cycle, so a stall must capture it then
      if (flush)
        hold_rdata <= 32'h0;
      else if ((m2_state == ST_LIVE) && !lsu_iq_ready_i)
        hold_rdata <= resp_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with an SRAM model and a response scoreboard.
// Expected responses are queued at accept time and compared when the consumer takes them.
module tb_lsu_mem_port;
  import lsu_mem_port_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        iq_lsu_valid_i;
  logic        iq_lsu_ready_o;
  iq_lsu_pkg_t iq_lsu_req_i;
  logic        lsu_iq_valid_o;
  logic        lsu_iq_ready_i;
  lsu_iq_pkg_t lsu_iq_resp_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata;

  logic [31:0] sram [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  int tests_run;
  int tests_failed;
  lsu_iq_pkg_t sb[$];
  logic        prev_stall;
  lsu_iq_pkg_t prev_resp;

  lsu_mem_port #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .iq_lsu_valid_i (iq_lsu_valid_i),
    .iq_lsu_ready_o (iq_lsu_ready_o),
    .iq_lsu_req_i   (iq_lsu_req_i),
    .lsu_iq_valid_o (lsu_iq_valid_o),
    .lsu_iq_ready_i (lsu_iq_ready_i),
    .lsu_iq_resp_o  (lsu_iq_resp_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read data valid one cycle after a read, garbage otherwise
  always @(posedge clk) begin
    if (pre_we) sram[pre_idx] <= pre_data;
    mem_rdata <= 32'hBAD0BAD0;
    if (mem_en_o) begin
      if (mem_we_o == 4'b0000) mem_rdata <= sram[mem_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) sram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
  end

  function automatic lsu_iq_pkg_t model_resp(input iq_lsu_pkg_t r, input logic [31:0] word);
    lsu_iq_pkg_t e;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    e = '0;
    bsel = word[8*r.vaddr[1:0] +: 8];
    hsel = r.vaddr[1] ? word[31:16] : word[15:0];
    if ((r.msize == 2'd1 && r.vaddr[0]) || (r.msize == 2'd2 && r.vaddr[1:0] != 2'b00)) begin
      e.execute_exc_info.execute_exception = 1'b1;
      e.execute_exc_info.exc_code          = 6'h09;
      e.execute_exc_info.badv              = r.vaddr;
    end else if (r.strb == 4'b0000) begin
      case (r.msize)
        2'd0:    e.rdata = r.msigned ? {{24{bsel[7]}}, bsel} : {24'h0, bsel};
        2'd1:    e.rdata = r.msigned ? {{16{hsel[15]}}, hsel} : {16'h0, hsel};
        default: e.rdata = word;
      endcase
    end
    return e;
  endfunction

  function automatic iq_lsu_pkg_t mk_req(input logic [1:0] msize, input logic msigned,
                                         input logic [31:0] vaddr, input logic [31:0] wdata,
                                         input logic [3:0] strb);
    iq_lsu_pkg_t r;
    r = '0;
    r.wid     = 4'h3;
    r.msize   = msize;
    r.msigned = msigned;
    r.vaddr   = vaddr;
    r.wdata   = wdata;
    r.strb    = strb;
    r.rmask   = 4'hF;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input iq_lsu_pkg_t req, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    iq_lsu_valid_i = valid;
    iq_lsu_req_i   = req;
    lsu_iq_ready_i = rdy;
    flush          = fl;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk);
    #1;
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  // Scoreboard: pop on a completing handshake, push on an accept, drop all on flush/reset
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && lsu_iq_valid_o)
        checkOutput("resp_stable", 128'(lsu_iq_resp_o), 128'(prev_resp));
      if (lsu_iq_valid_o && lsu_iq_ready_i) begin
        tests_run++;
        assert (sb.size() > 0)
        else begin
          tests_failed++;
          $error("[TB] FAIL sb_unexpected: observed response %0h expected none", lsu_iq_resp_o);
        end
        if (sb.size() > 0) checkOutput("sb_resp", 128'(lsu_iq_resp_o), 128'(sb.pop_front()));
      end
      if (iq_lsu_valid_i && iq_lsu_ready_o)
        sb.push_back(model_resp(iq_lsu_req_i, sram[iq_lsu_req_i.vaddr[9:2]]));
      prev_stall = lsu_iq_valid_o && !lsu_iq_ready_i;
      prev_resp  = lsu_iq_resp_o;
    end
  end

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    prev_stall     = 1'b0;
    prev_resp      = '0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    iq_lsu_valid_i = 1'b0;
    iq_lsu_req_i   = '0;
    lsu_iq_ready_i = 1'b0;
    pre_we         = 1'b0;
    pre_idx        = 8'h0;
    pre_data       = 32'h0;

    preload(8'h40, 32'hDEADBEEF);
    preload(8'h04, 32'hA5A50010);
    preload(8'h05, 32'h5A5A0014);
    preload(8'h80, 32'h00000000);
    #1;
    checkOutput("rst_valid", 128'(lsu_iq_valid_o), 128'(1'b0));
    checkOutput("rst_mem_en", 128'(mem_en_o), 128'(1'b0));
    checkOutput("rst_mem_we", 128'(mem_we_o), 128'(4'h0));
    checkOutput("rst_resp", 128'(lsu_iq_resp_o), 128'(0));
    checkOutput("rst_hold", 128'(dut.hold_rdata), 128'(32'h0));
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rst", 128'(iq_lsu_ready_o), 128'(1'b1));

    // Aligned word load
    applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h100, 32'h0, 4'h0), 1'b1, 1'b0);
    #1;
    checkOutput("lw_mem_en", 128'(mem_en_o), 128'(1'b1));
    checkOutput("lw_mem_we", 128'(mem_we_o), 128'(4'h0));
    checkOutput("lw_addr", 128'(mem_addr_o), 128'(32'h100));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("lw_valid", 128'(lsu_iq_valid_o), 128'(1'b1));
    checkOutput("lw_rdata", 128'(lsu_iq_resp_o.rdata), 128'(32'hDEADBEEF));
    checkOutput("lw_noexc", 128'(lsu_iq_resp_o.execute_exc_info), 128'(0));

    // Signed then unsigned byte load from lane 3, back to back
    preload(8'h40, 32'h80112233);
    applyStimulus(1'b1, mk_req(2'd0, 1'b1, 32'h103, 32'h0, 4'h0), 1'b1, 1'b0);
    #1;
    checkOutput("lb_addr", 128'(mem_addr_o), 128'(32'h100));
    applyStimulus(1'b1, mk_req(2'd0, 1'b0, 32'h103, 32'h0, 4'h0), 1'b1, 1'b0);
    #1;
    checkOutput("lb_signed", 128'(lsu_iq_resp_o.rdata), 128'(32'hFFFFFF80));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("lbu_unsigned", 128'(lsu_iq_resp_o.rdata), 128'(32'h00000080));

    // Upper-half store, then a misaligned word load right behind it
    applyStimulus(1'b1, mk_req(2'd1, 1'b0, 32'h202, 32'h0000ABCD, 4'b1100), 1'b1, 1'b0);
    #1;
    checkOutput("sh_mem_en", 128'(mem_en_o), 128'(1'b1));
    checkOutput("sh_mem_we", 128'(mem_we_o), 128'(4'b1100));
    checkOutput("sh_wdata", 128'(mem_wdata_o), 128'(32'hABCD0000));
    checkOutput("sh_addr", 128'(mem_addr_o), 128'(32'h200));
    applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h105, 32'h0, 4'h0), 1'b1, 1'b0);
    #1;
    checkOutput("ale_mem_en", 128'(mem_en_o), 128'(1'b0));
    checkOutput("ale_mem_we", 128'(mem_we_o), 128'(4'h0));
    checkOutput("sh_resp", 128'(lsu_iq_resp_o), 128'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("ale_exc", 128'(lsu_iq_resp_o.execute_exc_info.execute_exception), 128'(1'b1));
    checkOutput("ale_code", 128'(lsu_iq_resp_o.execute_exc_info.exc_code), 128'(6'h09));
    checkOutput("ale_badv", 128'(lsu_iq_resp_o.execute_exc_info.badv), 128'(32'h105));
    checkOutput("ale_rdata", 128'(lsu_iq_resp_o.rdata), 128'(32'h0));
    checkOutput("sh_sram", 128'(sram[8'h80]), 128'(32'hABCD0000));

    // Stall the consumer for three cycles behind a pending second load
    applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h10, 32'h0, 4'h0), 1'b1, 1'b0);
    applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h14, 32'h0, 4'h0), 1'b0, 1'b0);
    #1;
    checkOutput("stall_ready", 128'(iq_lsu_ready_o), 128'(1'b0));
    checkOutput("stall_mem_en", 128'(mem_en_o), 128'(1'b0));
    checkOutput("stall_rdata", 128'(lsu_iq_resp_o.rdata), 128'(32'hA5A50010));
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h14, 32'h0, 4'h0), 1'b0, 1'b0);
      #1;
      checkOutput("hold_state", 128'(dut.m2_state), 128'(ST_HOLD));
      checkOutput("hold_ready", 128'(iq_lsu_ready_o), 128'(1'b0));
      checkOutput("hold_rdata", 128'(lsu_iq_resp_o.rdata), 128'(32'hA5A50010));
    end
    applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h14, 32'h0, 4'h0), 1'b1, 1'b0);
    #1;
    checkOutput("release_ready", 128'(iq_lsu_ready_o), 128'(1'b1));
    checkOutput("release_addr", 128'(mem_addr_o), 128'(32'h14));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("second_rdata", 128'(lsu_iq_resp_o.rdata), 128'(32'h5A5A0014));

    // Flush while a response is parked in HOLD
    applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h10, 32'h0, 4'h0), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h14, 32'h0, 4'h0), 1'b0, 1'b1);
    #1;
    checkOutput("flush_ready", 128'(iq_lsu_ready_o), 128'(1'b0));
    checkOutput("flush_mem_en", 128'(mem_en_o), 128'(1'b0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("post_flush_valid", 128'(lsu_iq_valid_o), 128'(1'b0));
    checkOutput("post_flush_hold", 128'(dut.hold_rdata), 128'(32'h0));

    // Asynchronous reset while a response is LIVE
    applyStimulus(1'b1, mk_req(2'd2, 1'b0, 32'h100, 32'h0, 4'h0), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("live_valid", 128'(lsu_iq_valid_o), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 128'(lsu_iq_valid_o), 128'(1'b0));
    checkOutput("rst_mid_resp", 128'(lsu_iq_resp_o), 128'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      #1;
      checkOutput("no_stale_valid", 128'(lsu_iq_valid_o), 128'(1'b0));
    end

    // Fresh accepts after reset: signed and unsigned upper-half loads
    applyStimulus(1'b1, mk_req(2'd1, 1'b1, 32'h102, 32'h0, 4'h0), 1'b1, 1'b0);
    applyStimulus(1'b1, mk_req(2'd1, 1'b0, 32'h102, 32'h0, 4'h0), 1'b1, 1'b0);
    #1;
    checkOutput("lh_signed", 128'(lsu_iq_resp_o.rdata), 128'(32'hFFFF8011));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("lhu_unsigned", 128'(lsu_iq_resp_o.rdata), 128'(32'h00008011));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("sb_drained", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
